// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic a_signed(muldiv_op_e op);
        return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic b_signed(muldiv_op_e op);
        return op inside {OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Applies the recorded result signs and selects the op's output word.
// val holds the product for multiplies, {remainder, quotient} for divides.
module muldiv_signfix import muldiv_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  muldiv_op_e         op,
    input  logic               neg_q,
    input  logic               neg_r,
    input  logic [2*WIDTH-1:0] val,
    output logic [WIDTH-1:0]   res
);

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        prod_fix = neg_q ? -val : val;
        q_fix    = neg_q ? -val[WIDTH-1:0] : val[WIDTH-1:0];
        r_fix    = neg_r ? -val[2*WIDTH-1:WIDTH] : val[2*WIDTH-1:WIDTH];
        unique case (op)
            OpMul:                     res = prod_fix[WIDTH-1:0];
            OpMulh, OpMulhsu, OpMulhu: res = prod_fix[2*WIDTH-1:WIDTH];
            OpDiv, OpDivu:             res = q_fix;
            default:                   res = r_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one operand bit per cycle on magnitudes,
// sign fix-up in a final cycle. Divide-by-zero and signed overflow skip the loop.
module muldiv_iter import muldiv_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);

    muldiv_state_e      state;
    muldiv_op_e         op_q;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   mcand;  // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;

    muldiv_op_e         op_in;
    logic               sa, sb, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b, mul_add;
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [WIDTH-1:0]   fixed;

    always_comb begin
        op_in    = muldiv_op_e'(op);
        sa       = a_signed(op_in) && a[WIDTH-1];
        sb       = b_signed(op_in) && b[WIDTH-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        div_zero = is_div(op_in) && (b == '0);
        div_ovf  = is_div(op_in) && a_signed(op_in) && (b == '1) &&
                   (a == {1'b1, {(WIDTH-1){1'b0}}});
        mul_add  = prod[0] ? mcand : '0;
        add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        shifted  = {rem, quot[WIDTH-1]};
        diff     = shifted - {1'b0, mcand};
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .op    (op_q),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .val   (is_div(op_q) ? {rem, quot} : prod),
        .res   (fixed)
    );

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            op_q   <= OpMul;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mcand  <= '0;
            prod   <= '0;
            rem    <= '0;
            quot   <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !kill) begin
                        op_q  <= op_in;
                        cnt   <= CW'(WIDTH - 1);
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        mcand <= is_div(op_in) ? mag_b : mag_a;
                        prod  <= {{WIDTH{1'b0}}, mag_b};
                        rem   <= '0;
                        quot  <= mag_a;
                        state <= StCalc;
                        // Preset raw results; sign flags cleared so fix-up passes them through.
                        if (div_zero) begin
                            quot  <= '1;
                            rem   <= a;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= StFix;
                        end else if (div_ovf) begin
                            quot  <= a;
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= StFix;
                        end
                    end
                end
                StCalc: begin
                    if (kill) begin
                        state <= StIdle;
                    end else begin
                        if (is_div(op_q)) begin
                            rem  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
                        end else begin
                            prod <= {add_sum, prod[WIDTH-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= StFix;
                        end
                    end
                end
                StFix: begin
                    state <= StIdle;
                    if (!kill) begin
                        result <= fixed;
                        done   <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
